// File: rtl/pulse_scheduler.sv
// Multi-channel periodic pulse generator: one period counter, NCH compare
// channels, shadowed configuration that only changes while idle or at a wrap.
module pulse_scheduler #(
   parameter int WIDTH = 5,
   parameter int NCH   = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   cfg_load,
   input  logic [WIDTH-1:0]       cfg_period,
   input  logic [NCH*WIDTH-1:0]   cfg_cmp,
   input  logic [NCH-1:0]         cfg_ch_en,
   input  logic                   cfg_oneshot,
   output logic [NCH-1:0]         pulse,
   output logic                   any_pulse,
   output logic                   wrap,
   output logic                   busy,
   output logic                   cfg_pend,
   output logic [WIDTH-1:0]       count
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     count_q, count_d;
   logic [WIDTH-1:0]     per_q, per_d, pper_q, pper_d;
   logic [NCH*WIDTH-1:0] cmp_q, cmp_d, pcmp_q, pcmp_d;
   logic [NCH-1:0]       en_q, en_d, pen_q, pen_d;
   logic                 os_q, os_d, pos_q, pos_d;
   logic                 pend_q, pend_d;
   logic [NCH-1:0]       pulse_q, pulse_d;
   logic                 any_q, any_d;
   logic                 wrap_q, wrap_d;
   logic                 busy_q, busy_d;
   logic                 at_end;

   assign at_end = (count_q == per_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      per_d   = per_q;
      cmp_d   = cmp_q;
      en_d    = en_q;
      os_d    = os_q;
      pper_d  = pper_q;
      pcmp_d  = pcmp_q;
      pen_d   = pen_q;
      pos_d   = pos_q;
      pend_d  = pend_q;
      busy_d  = busy_q;
      pulse_d = '0;
      wrap_d  = 1'b0;

      if (state_q == IDLE) begin
         count_d = '0;
         if (cfg_load) begin
            per_d = cfg_period;
            cmp_d = cfg_cmp;
            en_d  = cfg_ch_en;
            os_d  = cfg_oneshot;
         end
         if (start && !stop) begin
            state_d = RUN;
            busy_d  = 1'b1;
         end
      end else if (stop) begin
         // Abort: a waiting configuration still takes effect, a same-edge load wins over it.
         state_d = IDLE;
         busy_d  = 1'b0;
         count_d = '0;
         pend_d  = 1'b0;
         if (pend_q) begin
            per_d = pper_q;
            cmp_d = pcmp_q;
            en_d  = pen_q;
            os_d  = pos_q;
         end
         if (cfg_load) begin
            per_d = cfg_period;
            cmp_d = cfg_cmp;
            en_d  = cfg_ch_en;
            os_d  = cfg_oneshot;
         end
      end else begin
         for (int i = 0; i < NCH; i++)
            pulse_d[i] = en_q[i] && (count_q == cmp_q[i*WIDTH +: WIDTH]);
         wrap_d = at_end;
         if (at_end) begin
            count_d = '0;
            pend_d  = 1'b0;
            if (pend_q) begin
               per_d = pper_q;
               cmp_d = pcmp_q;
               en_d  = pen_q;
               os_d  = pos_q;
            end
            if (cfg_load) begin
               per_d = cfg_period;
               cmp_d = cfg_cmp;
               en_d  = cfg_ch_en;
               os_d  = cfg_oneshot;
            end
            if (os_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end else begin
            count_d = count_q + WIDTH'(1);
            if (cfg_load) begin
               pper_d = cfg_period;
               pcmp_d = cfg_cmp;
               pen_d  = cfg_ch_en;
               pos_d  = cfg_oneshot;
               pend_d = 1'b1;
            end
         end
      end

      any_d = |pulse_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         per_q   <= '1;
         cmp_q   <= '0;
         en_q    <= '0;
         os_q    <= 1'b0;
         pper_q  <= '0;
         pcmp_q  <= '0;
         pen_q   <= '0;
         pos_q   <= 1'b0;
         pend_q  <= 1'b0;
         pulse_q <= '0;
         any_q   <= 1'b0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         per_q   <= per_d;
         cmp_q   <= cmp_d;
         en_q    <= en_d;
         os_q    <= os_d;
         pper_q  <= pper_d;
         pcmp_q  <= pcmp_d;
         pen_q   <= pen_d;
         pos_q   <= pos_d;
         pend_q  <= pend_d;
         pulse_q <= pulse_d;
         any_q   <= any_d;
         wrap_q  <= wrap_d;
         busy_q  <= busy_d;
      end
   end

   assign pulse     = pulse_q;
   assign any_pulse = any_q;
   assign wrap      = wrap_q;
   assign busy      = busy_q;
   assign cfg_pend  = pend_q;
   assign count     = count_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: expected strobe events are queued
// per scenario and compared cycle by cycle against pulse/any_pulse/wrap.
module tb_pulse_scheduler;

   localparam int W = 5;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start, stop, cfg_load, cfg_oneshot;
   logic [W-1:0]   cfg_period;
   logic [N*W-1:0] cfg_cmp;
   logic [N-1:0]   cfg_ch_en;
   logic [N-1:0]   pulse;
   logic           any_pulse, wrap, busy, cfg_pend;
   logic [W-1:0]   count;

   typedef struct {
      int           t;
      logic [N-1:0] p;
      logic         w;
   } ev_t;

   ev_t sb[$];
   int  cyc;
   int  n_tests = 0;
   int  n_fail  = 0;

   pulse_scheduler #(.WIDTH(W), .NCH(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_load(cfg_load), .cfg_period(cfg_period), .cfg_cmp(cfg_cmp),
      .cfg_ch_en(cfg_ch_en), .cfg_oneshot(cfg_oneshot),
      .pulse(pulse), .any_pulse(any_pulse), .wrap(wrap), .busy(busy),
      .cfg_pend(cfg_pend), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Expected strobes for edges t_from..t_to, where the counter was 0 before edge off+1.
   task automatic push_periodic(input int t_from, input int t_to, input int off,
                                input int per, input logic [N*W-1:0] cmpv,
                                input logic [N-1:0] en);
      for (int t = t_from; t <= t_to; t++) begin
         ev_t e;
         int  pos;
         pos = (t - 1 - off) % (per + 1);
         e.t = t;
         e.w = (pos == per);
         for (int i = 0; i < N; i++)
            e.p[i] = en[i] && (pos == int'(cmpv[i*W +: W]));
         if (e.w || e.p != '0) sb.push_back(e);
      end
   endtask

   task automatic run_cycles(input int n, input int busy_until);
      for (int k = 0; k < n; k++) begin
         ev_t e;
         tick();
         e.t = cyc;
         e.p = '0;
         e.w = 1'b0;
         if (sb.size() > 0 && sb[0].t == cyc) e = sb.pop_front();
         chk("pulse", pulse, e.p);
         chk("wrap", wrap, e.w);
         chk("any_pulse", any_pulse, |e.p);
         chk("busy", busy, cyc < busy_until);
      end
   endtask

   task automatic load_cfg(input int per, input logic [N*W-1:0] cmpv,
                           input logic [N-1:0] en, input logic os, input int busy_until);
      cfg_period  = W'(per);
      cfg_cmp     = cmpv;
      cfg_ch_en   = en;
      cfg_oneshot = os;
      cfg_load    = 1'b1;
      run_cycles(1, busy_until);
      cfg_load    = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 0;
      chk("start_busy", busy, 1);
      chk("start_count", count, 0);
   endtask

   task automatic do_stop(input string tag);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_pulse"}, pulse, 0);
      chk({tag, "_any"}, any_pulse, 0);
      chk({tag, "_wrap"}, wrap, 0);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_load = 1'b0;
      cfg_period = '0; cfg_cmp = '0; cfg_ch_en = '0; cfg_oneshot = 1'b0;
      cyc = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pulse", pulse, 0);
      chk("rst_any", any_pulse, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pend", cfg_pend, 0);
      chk("rst_count", count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous, three channels
      load_cfg(31, {5'd24, 5'd20, 5'd4}, 3'b111, 1'b0, 0);
      chk("idle_load_pend", cfg_pend, 0);
      do_start();
      push_periodic(1, 70, 0, 31, {5'd24, 5'd20, 5'd4}, 3'b111);
      run_cycles(70, 1000);
      chk("cont_count", count, 6);
      do_stop("stop1");

      // One-shot
      load_cfg(9, {5'd0, 5'd0, 5'd3}, 3'b001, 1'b1, 0);
      do_start();
      sb.push_back('{t: 4, p: 3'b001, w: 1'b0});
      sb.push_back('{t: 10, p: 3'b000, w: 1'b1});
      run_cycles(20, 10);
      chk("os_count", count, 0);
      chk("os_sb_empty", sb.size(), 0);

      // Mid-run reconfiguration to a 16-cycle period
      load_cfg(31, {5'd24, 5'd20, 5'd4}, 3'b111, 1'b0, 0);
      do_start();
      push_periodic(1, 32, 0, 31, {5'd24, 5'd20, 5'd4}, 3'b111);
      push_periodic(33, 70, 32, 15, {5'd24, 5'd20, 5'd4}, 3'b111);
      run_cycles(10, 1000);
      load_cfg(15, {5'd24, 5'd20, 5'd4}, 3'b111, 1'b0, 1000);
      chk("mid_pend_set", cfg_pend, 1);
      run_cycles(20, 1000);
      chk("mid_pend_hold", cfg_pend, 1);
      run_cycles(1, 1000);
      chk("mid_pend_clr", cfg_pend, 0);
      run_cycles(38, 1000);
      chk("mid_count", count, 6);
      do_stop("stop2");

      // period = 0
      load_cfg(0, {5'd0, 5'd0, 5'd0}, 3'b001, 1'b0, 0);
      do_start();
      push_periodic(1, 8, 0, 0, {5'd0, 5'd0, 5'd0}, 3'b001);
      run_cycles(8, 1000);
      do_stop("stop3");

      // cmp beyond period never fires
      load_cfg(5, {5'd0, 5'd7, 5'd2}, 3'b011, 1'b0, 0);
      do_start();
      push_periodic(1, 20, 0, 5, {5'd0, 5'd7, 5'd2}, 3'b011);
      run_cycles(20, 1000);
      do_stop("stop4");

      // start and stop together while idle
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy", busy, 0);
      chk("ss_count", count, 0);
      run_cycles(3, 0);

      // stop on the compare edge suppresses the pulse
      load_cfg(31, {5'd0, 5'd0, 5'd4}, 3'b001, 1'b0, 0);
      do_start();
      run_cycles(4, 1000);
      chk("pre_stop_count", count, 4);
      do_stop("stop_cmp");
      run_cycles(3, 0);

      // reset mid-run with a pending configuration
      load_cfg(31, {5'd24, 5'd20, 5'd4}, 3'b111, 1'b0, 0);
      do_start();
      push_periodic(1, 6, 0, 31, {5'd24, 5'd20, 5'd4}, 3'b111);
      run_cycles(5, 1000);
      load_cfg(3, {5'd0, 5'd0, 5'd0}, 3'b111, 1'b0, 1000);
      chk("rst_pre_pend", cfg_pend, 1);
      sb.delete();
      rst_n = 1'b0;
      #2;
      chk("arst_pulse", pulse, 0);
      chk("arst_any", any_pulse, 0);
      chk("arst_wrap", wrap, 0);
      chk("arst_busy", busy, 0);
      chk("arst_pend", cfg_pend, 0);
      chk("arst_count", count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      push_periodic(1, 66, 0, 31, {5'd0, 5'd0, 5'd0}, 3'b000);
      run_cycles(66, 1000);
      chk("post_rst_sb_empty", sb.size(), 0);
      do_stop("stop5");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
